sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Owns the single port of the 64 KB sram64k and decides, per clock, which requester drives it: the boot flash loader, the 6502 CPU bus, or the diagnostics SPI engine.
- Replaces the static read_complete/halt muxing with a mode FSM and a phi2-synchronised CPU access window.
- Lets diagnostics steal idle cycles while the CPU runs, not only while it is halted.
- Sits between spi_flash_reader, ramenable, diagnostics and sram64k inside enable_logic.

Parameters:
SETTLE_CYCLES, 2, clk cycles after synchronised phi2 rise before the CPU window opens
CPU_SLOT, 4, length of the CPU window in clk cycles (>=2)
STARVE_LIMIT, 255, consecutive pending diag cycles before diag_starve asserts (8-bit counter)

Ports:
clk  in  1  internal HFOSC clock
rst  in  1  reset, asynchronous, active-low
load_done  in  1  flash image load complete (read_complete)
halt  in  1  CPU halt request from diagnostics
phi2  in  1  CPU phase-2 clock, asynchronous to clk
cpu_address  in  16  CPU address bus
cpu_wdata  in  8  CPU data bus input
cpu_cs  in  1  RAM select from ramenable, qualified by load_done
cpu_we  in  1  write enable from ramenable
flash_req  in  1  flash loader access request
flash_we  in  1  flash loader write
flash_addr  in  16  flash loader address
flash_wdata  in  8  flash loader write data
flash_gnt  out  1  flash access accepted this cycle
diag_req  in  1  diagnostics access request, held until granted
diag_we  in  1  diagnostics write
diag_addr  in  16  diagnostics address
diag_wdata  in  8  diagnostics write data
diag_gnt  out  1  one-cycle grant pulse
diag_rvalid  out  1  diag read data valid on ram_dataout
ram_address  out  16  to sram64k
ram_datain  out  8  to sram64k
ram_cs  out  1  to sram64k
ram_we  out  1  to sram64k
cpu_window  out  1  CPU owns the RAM this cycle
mode  out  2  00 BOOT, 01 RUN, 10 HALTED
diag_starve  out  1  sticky starvation flag

Behaviour:
- All outputs registered. Reset (rst=0, async) forces mode=BOOT, all strobes/flags 0, ram_address=0, ram_datain=0, window counter idle, starve counter 0.
- phi2 and halt pass through 2-flop synchronisers. Rise is detected on the synchronised phi2.
- Mode FSM:
  - BOOT->RUN on load_done=1. load_done is sticky once seen; a later fall is ignored.
  - RUN->HALTED on halt_sync=1 with cpu_window=0. An open window always completes first.
  - HALTED->RUN on halt_sync=0. HALTED never returns to BOOT except by reset.
- BOOT:
  - flash_gnt = flash_req each cycle.
  - ram_* take the flash_* values one cycle later.
  - CPU and diag are never granted.
- CPU window (RUN only):
  - Opens SETTLE_CYCLES after the phi2 rise and stays open exactly CPU_SLOT cycles.
  - ram_address = cpu_address and ram_cs = cpu_cs throughout.
  - ram_we = cpu_cs & cpu_we in the final window cycle only.
  - A phi2 rise that arrives while the window is open is ignored; there is no re-trigger.
- Diag grant:
  - RUN: granted when diag_req=1, phi2_sync=0, cpu_window=0, and the window is not scheduled to open next cycle. The window wins a simultaneous conflict.
  - HALTED: granted any cycle diag_req=1.
  - diag_gnt pulses 1 cycle; the ram_* drive follows one cycle later.
  - For reads, diag_rvalid pulses exactly 2 cycles after diag_gnt (registered sram output). No new diag grant is issued until that rvalid has occurred.
  - In RUN, the diag access and its rvalid complete even if a phi2 rise occurs meanwhile. SETTLE_CYCLES>=2 guarantees no overlap.
- Idle cycles: ram_cs=0, ram_we=0, address held.
- Starvation:
  - An 8-bit counter increments each RUN cycle with diag_req=1 and no grant, saturating.
  - At STARVE_LIMIT, diag_starve=1. It clears on the next diag_gnt.
  - The counter resets on grant and on mode change.
- The mode output reflects the registered state.

Test Plan:
- Reset then flash writes: flash_req=1, we=1, addr 0x0000..0x0003, data A0..A3 -> flash_gnt each cycle, ram_we=1 with matching addr/data 1 cycle later; diag_req=1 never granted while mode=00.
- load_done pulse then CPU read: phi2 rises, cpu_cs=1, addr 0xF000 -> mode=01, cpu_window high SETTLE+sync cycles after the rise for exactly 4 cycles, ram_we=0.
- CPU write: cpu_we=1, addr 0x8000, data 0x55 -> ram_we=1 only in the 4th window cycle with ram_datain=0x55.
- Diag read in RUN: diag_req asserted during phi2 high -> no grant until phi2_sync low; diag_gnt 1 cycle; diag_rvalid 2 cycles later; never overlaps cpu_window.
- Halt mid-window: halt=1 in window cycle 2 -> window finishes its 4 cycles, then mode=10; back-to-back diag reads granted every 3rd cycle; halt=0 -> mode=01.
- Starvation and async reset: STARVE_LIMIT=4, phi2 held high in RUN with diag_req=1 -> diag_starve=1 after 4 cycles, clears on grant. rst=0 mid-window -> all outputs 0, mode=00 immediately.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Arbitrates the single sram64k port between the flash loader, the 6502 bus and diagnostics.
// A mode FSM (BOOT/RUN/HALTED) schedules a phi2-aligned CPU window and lets diagnostics use idle cycles.
module sram_port_arbiter #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CPU_SLOT      = 4,
    parameter int STARVE_LIMIT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_done,
    input  logic        halt,
    input  logic        phi2,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_cs,
    input  logic        cpu_we,
    input  logic        flash_req,
    input  logic        flash_we,
    input  logic [15:0] flash_addr,
    input  logic [7:0]  flash_wdata,
    output logic        flash_gnt,
    input  logic        diag_req,
    input  logic        diag_we,
    input  logic [15:0] diag_addr,
    input  logic [7:0]  diag_wdata,
    output logic        diag_gnt,
    output logic        diag_rvalid,
    output logic [15:0] ram_address,
    output logic [7:0]  ram_datain,
    output logic        ram_cs,
    output logic        ram_we,
    output logic        cpu_window,
    output logic [1:0]  mode,
    output logic        diag_starve
);

    typedef enum logic [1:0] {
        MODE_BOOT   = 2'b00,
        MODE_RUN    = 2'b01,
        MODE_HALTED = 2'b10
    } mode_t;

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int WW = $clog2(CPU_SLOT + 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [WW-1:0] SLOT_LOAD   = WW'(CPU_SLOT);
    localparam logic [8:0]    STARVE_LIM9 = 9'(STARVE_LIMIT);

    // bit 0: phi2, bit 1: halt
    logic [1:0] sync_in;
    logic [1:0] sync_out;
    assign sync_in = {halt, phi2};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= sync_in[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync_out[gi] = sync_reg;
        end
    endgenerate

    logic phi2_sync;
    logic halt_sync;
    assign phi2_sync = sync_out[0];
    assign halt_sync = sync_out[1];

    mode_t         state_reg;
    mode_t         state_next;
    logic          phi2_prev_reg;
    logic [SW-1:0] settle_cnt_reg;
    logic [WW-1:0] win_cnt_reg;
    logic          diag_drive_reg;
    logic          diag_we_reg;
    logic [15:0]   diag_addr_reg;
    logic [7:0]    diag_wdata_reg;
    logic [7:0]    starve_cnt_reg;

    logic       in_boot;
    logic       in_run;
    logic       in_halted;
    logic       start_settle;
    logic       open_next;
    logic       window_next;
    logic       final_next;
    logic       diag_busy;
    logic       grant_now;
    logic [8:0] starve_inc;

    assign mode = state_reg;

    always_comb begin
        in_boot      = (state_reg == MODE_BOOT);
        in_run       = (state_reg == MODE_RUN);
        in_halted    = (state_reg == MODE_HALTED);
        start_settle = in_run & phi2_sync & ~phi2_prev_reg;
        open_next    = (settle_cnt_reg == SW'(1));
        window_next  = open_next | (win_cnt_reg > WW'(1));
        final_next   = ~open_next & (win_cnt_reg == WW'(2));
        // A read stays outstanding until its rvalid has been issued
        diag_busy    = diag_gnt | (diag_drive_reg & ~diag_we_reg);
        grant_now    = diag_req & ~diag_busy &
                       (in_halted | (in_run & ~phi2_sync & ~cpu_window & ~open_next));
        starve_inc   = {1'b0, starve_cnt_reg} + 9'd1;

        state_next = state_reg;
        case (state_reg)
            MODE_BOOT:   if (load_done) state_next = MODE_RUN;
            MODE_RUN:    if (halt_sync && !cpu_window && settle_cnt_reg == '0)
                             state_next = MODE_HALTED;
            MODE_HALTED: if (!halt_sync) state_next = MODE_RUN;
            default:     state_next = MODE_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= MODE_BOOT;
            phi2_prev_reg  <= 1'b0;
            settle_cnt_reg <= '0;
            win_cnt_reg    <= '0;
            cpu_window     <= 1'b0;
            diag_gnt       <= 1'b0;
            diag_drive_reg <= 1'b0;
            diag_rvalid    <= 1'b0;
            diag_we_reg    <= 1'b0;
            diag_addr_reg  <= '0;
            diag_wdata_reg <= '0;
            flash_gnt      <= 1'b0;
            ram_address    <= '0;
            ram_datain     <= '0;
            ram_cs         <= 1'b0;
            ram_we         <= 1'b0;
            starve_cnt_reg <= '0;
            diag_starve    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phi2_prev_reg <= phi2_sync;

            // Rises during settle or an open window fall through this chain unseen
            if (open_next) begin
                settle_cnt_reg <= '0;
                win_cnt_reg    <= SLOT_LOAD;
                cpu_window     <= 1'b1;
            end else if (settle_cnt_reg != '0) begin
                settle_cnt_reg <= settle_cnt_reg - SW'(1);
            end else if (win_cnt_reg != '0) begin
                win_cnt_reg <= win_cnt_reg - WW'(1);
                cpu_window  <= (win_cnt_reg > WW'(1));
            end else if (start_settle) begin
                settle_cnt_reg <= SETTLE_LOAD;
            end

            diag_gnt       <= grant_now;
            diag_drive_reg <= diag_gnt;
            diag_rvalid    <= diag_drive_reg & ~diag_we_reg;
            if (grant_now) begin
                diag_we_reg    <= diag_we;
                diag_addr_reg  <= diag_addr;
                diag_wdata_reg <= diag_wdata;
            end

            flash_gnt <= in_boot & flash_req;
            if (in_boot) begin
                if (flash_req) begin
                    ram_address <= flash_addr;
                    ram_datain  <= flash_wdata;
                    ram_cs      <= 1'b1;
                    ram_we      <= flash_we;
                end else begin
                    ram_cs <= 1'b0;
                    ram_we <= 1'b0;
                end
            end else if (window_next) begin
                ram_address <= cpu_address;
                ram_datain  <= cpu_wdata;
                ram_cs      <= cpu_cs;
                ram_we      <= cpu_cs & cpu_we & final_next;
            end else if (diag_gnt) begin
                ram_address <= diag_addr_reg;
                ram_datain  <= diag_wdata_reg;
                ram_cs      <= 1'b1;
                ram_we      <= diag_we_reg;
            end else begin
                ram_cs <= 1'b0;
                ram_we <= 1'b0;
            end

            if (grant_now) begin
                starve_cnt_reg <= '0;
                diag_starve    <= 1'b0;
            end else if (state_next != state_reg) begin
                starve_cnt_reg <= '0;
            end else if (in_run && diag_req) begin
                if (starve_cnt_reg != 8'hFF)
                    starve_cnt_reg <= starve_inc[7:0];
                if (starve_inc >= STARVE_LIM9)
                    diag_starve <= 1'b1;
            end
        end
    end

endmodule
